// File: rtl/ft_pkg.sv
// Shared definitions for the fault-tolerant recovery blocks: restore FSM
// states and the checkpoint memory word layout.
package ft_pkg;

   typedef enum logic [1:0] {
      RL_IDLE,
      RL_REQ,
      RL_WAIT,
      RL_FINISH
   } ft_rl_state_e;

   localparam int unsigned FT_WORD_BYTES = 4;

   // The saved PC sits in the slot right after the last register.
   function automatic logic [31:0] ft_pc_offset(input int unsigned num_regs);
      return num_regs * FT_WORD_BYTES;
   endfunction

endpackage

// File: rtl/ft_recovery_loader.sv
// Restore engine: reads the checkpointed register file and PC from FT memory
// one word at a time, replays them into the core, then pulses done_o.
module ft_recovery_loader
   import ft_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  recover_i,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [31:0]           data_addr_o,
   output logic [31:0]           data_wdata_o,
   input  logic [31:0]           data_rdata_i,
   input  logic                  data_err_i,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  pc_set_o,
   output logic [31:0]           pc_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int unsigned      IDX_W  = $clog2(NUM_REGS + 1);
   localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(NUM_REGS);

   ft_rl_state_e          state_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  rf_we_q;
   logic [ADDR_WIDTH-1:0] rf_waddr_q;
   logic [DATA_WIDTH-1:0] rf_wdata_q;
   logic                  pc_set_q;
   logic [31:0]           pc_q;
   logic                  done_q;
   logic                  err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RL_IDLE;
         idx_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         pc_set_q   <= 1'b0;
         pc_q       <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rf_we_q  <= 1'b0;
         pc_set_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            RL_IDLE: begin
               if (recover_i) begin
                  idx_q   <= IDX_W'(1);
                  err_q   <= 1'b0;
                  state_q <= RL_REQ;
               end
            end
            RL_REQ: begin
               if (data_gnt_i) begin
                  state_q <= RL_WAIT;
               end
            end
            RL_WAIT: begin
               if (data_rvalid_i) begin
                  if (data_err_i) begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= RL_FINISH;
                  end else if (idx_q == PC_IDX) begin
                     pc_set_q <= 1'b1;
                     pc_q     <= data_rdata_i;
                     done_q   <= 1'b1;
                     state_q  <= RL_FINISH;
                  end else begin
                     rf_we_q    <= 1'b1;
                     rf_waddr_q <= idx_q[ADDR_WIDTH-1:0];
                     rf_wdata_q <= DATA_WIDTH'(data_rdata_i);
                     idx_q      <= idx_q + IDX_W'(1);
                     state_q    <= RL_REQ;
                  end
               end
            end
            RL_FINISH: begin
               state_q <= RL_IDLE;
            end
            default: begin
               state_q <= RL_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      data_req_o  = (state_q == RL_REQ);
      data_addr_o = '0;
      if (state_q == RL_REQ) begin
         if (idx_q == PC_IDX) begin
            data_addr_o = BASE_ADDR + ft_pc_offset(NUM_REGS);
         end else begin
            data_addr_o = BASE_ADDR + (32'(idx_q) * FT_WORD_BYTES);
         end
      end
   end

   assign data_we_o    = 1'b0;
   assign data_be_o    = 4'hF;
   assign data_wdata_o = '0;
   assign rf_we_o      = rf_we_q;
   assign rf_waddr_o   = rf_waddr_q;
   assign rf_wdata_o   = rf_wdata_q;
   assign pc_set_o     = pc_set_q;
   assign pc_o         = pc_q;
   assign busy_o       = (state_q != RL_IDLE);
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: doc/ft_recovery_loader.md
# ft_recovery_loader

Initiator-side restore engine for a core under fault-tolerant recovery. When the FT controller signals recovery, this block issues read requests over the FT memory's data port (req/gnt/rvalid protocol) for the checkpointed register file and PC. Each returned word goes to the core's register-file write port; the final word, the saved PC, is loaded into the core's PC. The block then pulses `done_o`, which drives the FT module's `done_i`. It sits between the core and the FT memory port.

## Interface
- `ADDR_WIDTH`, 5: register-file address width.
- `DATA_WIDTH`, 32: register/data width.
- `NUM_REGS`, 32: architectural registers. x0 is never restored.
- `BASE_ADDR`, 32'h0: byte address of the register-0 slot in the FT memory.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `recover_i` in 1: recovery request (level) from the FT controller.
- `data_req_o` out 1: read request.
- `data_gnt_i` in 1: request granted.
- `data_rvalid_i` in 1: read data valid.
- `data_we_o` out 1: constant 0.
- `data_be_o` out 4: constant 4'hF.
- `data_addr_o` out 32: byte address of the request.
- `data_wdata_o` out 32: constant 0.
- `data_rdata_i` in 32: read data.
- `data_err_i` in 1: error, qualified by `data_rvalid_i`.
- `rf_we_o` out 1: register-file write strobe.
- `rf_waddr_o` out ADDR_WIDTH: register index.
- `rf_wdata_o` out DATA_WIDTH: restored value.
- `pc_set_o` out 1: PC load strobe.
- `pc_o` out 32: restored PC.
- `busy_o` out 1: high from the first REQ cycle through FINISH.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky error. Cleared on the next accepted `recover_i`.

## Operation
- **Word map:**
  - Word index k = 1..NUM_REGS-1 is register k, at `BASE_ADDR + 4*k`.
  - k = NUM_REGS is the PC, at `BASE_ADDR + 4*NUM_REGS`.
- **FSM states:** IDLE, REQ, WAIT, FINISH.
- **IDLE:** `recover_i`=1 sets idx←1, clears `err_o`, and moves to REQ.
- **REQ:**
  - `data_req_o`=1 with `data_addr_o` = word address of idx.
  - The address stays stable until `data_gnt_i`.
  - On `data_gnt_i`, move to WAIT.
- **WAIT:**
  - `data_req_o`=0. Wait for `data_rvalid_i`.
  - rvalid with `data_err_i`=1: set `err_o`, skip the write, go to FINISH (abort).
  - rvalid, no error, idx<NUM_REGS: register a write of rf[idx]←rdata, increment idx, return to REQ.
  - rvalid, no error, idx==NUM_REGS: register the PC load, go to FINISH.
- **FINISH:** `done_o`=1 for one cycle, then IDLE.
- **Ignored events:**
  - `recover_i` outside IDLE.
  - `data_rvalid_i` outside WAIT.
  - `data_gnt_i` outside REQ.
- **Transactions:** exactly one outstanding at a time.
- **Widths:** idx is $clog2(NUM_REGS+1) bits. `rf_waddr_o` = idx[ADDR_WIDTH-1:0].

## Timing
- **Reset values:** all outputs 0 except `data_be_o`=4'hF. State is IDLE.
- **Reset mid-operation:** asynchronous return to IDLE. Outputs clear immediately. No partial write or done pulse is issued after deassertion.
- **Start latency:** `recover_i` sampled at edge N puts `data_req_o` high in cycle N+1.
- **Request outputs:** `data_req_o`/`data_addr_o` decode combinationally from state and idx.
- **Write strobes:**
  - `rf_we_o`/`pc_set_o` are registered single-cycle pulses.
  - They appear in the cycle after the accepting `data_rvalid_i`.
  - That cycle coincides with the next REQ, or with FINISH.
- **Last write vs. done:** the final `pc_set_o` and `done_o` are asserted in the same cycle.
- **Best case:** immediate gnt and rvalid one cycle later gives 2 cycles/word. 32 words take 64 cycles, and `done_o` is asserted at cycle 65.
- **Stalls:** gnt and rvalid may each be delayed arbitrarily; the FSM holds.

## Structure
- Shared package `ft_pkg`:
  - state enum `ft_rl_state_e`.
  - constant `FT_WORD_BYTES`=4.
  - PC slot offset function of `NUM_REGS`.
- No sub-module; a single FSM plus an index counter.

## Test plan
- **Nominal restore:** responder grants immediately, rvalid +1 cycle, rdata=0x1000+k.
  - 31 `rf_we_o` pulses with waddr k and wdata 0x1000+k.
  - `pc_set_o` with `pc_o`=0x1020.
  - `done_o` at cycle 65. `err_o`=0.
- **Grant stall:** `data_gnt_i` withheld 5 cycles on word 3.
  - `data_req_o` held with `data_addr_o`=0xC for all 5 cycles.
  - No duplicate request.
- **Error abort:** `data_err_i`=1 with rvalid on word 7.
  - Writes for k=1..6 only. No `pc_set_o`.
  - `done_o` pulses. `err_o` stays 1 until the next `recover_i`.
- **Spurious events:** rvalid in REQ, gnt in WAIT, and `recover_i` re-asserted while busy.
  - All ignored; the sequence matches the nominal case.
- **Reset mid-operation:** `rst_ni` low during word 10.
  - All outputs 0 immediately.
  - After release, a fresh `recover_i` restarts at address `BASE_ADDR+4`.
